// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch, decode, execute and retire one
// instruction at a time, feeding branch_control and holding pc/ir.
module pc_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_ack,
   input  logic [31:0] instr,
   input  logic        alu_done,
   input  logic [31:0] incr_pc,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic [1:0]  counter_selector,
   output logic [2:0]  brtype,
   output logic        halted,
   output logic [15:0] retired
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      UPDATE,
      HALT
   } state_t;

   state_t state;
   state_t state_d;

   logic [2:0] cls;
   logic       is_br;
   logic       is_jl;
   logic       is_jr;
   logic       is_halt;
   logic       is_alu;
   logic [1:0] sel_d;
   logic [2:0] bt_d;

   assign cls     = ir[31:29];
   assign is_br   = (cls == 3'b001);
   assign is_jl   = (cls == 3'b010);
   assign is_jr   = (cls == 3'b011);
   assign is_halt = (cls == 3'b111);
   // Classes 100/101/110 fall through to ALU handling.
   assign is_alu  = !(is_br || is_jl || is_jr || is_halt);

   always_comb begin
      sel_d = 2'd0;
      bt_d  = 3'd0;
      unique case (1'b1)
         is_br: bt_d = ir[28:26];
         is_jl: sel_d = 2'd1;
         is_jr: sel_d = 2'd2;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:   state_d = FETCH;
         FETCH:  if (imem_ack) state_d = DECODE;
         DECODE: state_d = is_halt ? HALT : EXEC;
         EXEC:   if (!is_alu || alu_done) state_d = UPDATE;
         UPDATE: state_d = FETCH;
         HALT:   state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         pc               <= 32'd0;
         ir               <= 32'd0;
         counter_selector <= 2'd0;
         brtype           <= 3'd0;
         retired          <= 16'd0;
      end else begin
         state <= state_d;
         if (state == FETCH && imem_ack) begin
            ir <= instr;
         end
         if (state == DECODE) begin
            counter_selector <= sel_d;
            brtype           <= bt_d;
         end
         // Selects read as zero for the whole fetch of the next word.
         if (state_d == FETCH) begin
            counter_selector <= 2'd0;
            brtype           <= 3'd0;
         end
         if (state == UPDATE) begin
            pc      <= incr_pc;
            retired <= retired + 16'd1;
         end
      end
   end

   assign imem_req = (state == FETCH);
   assign halted   = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an
// instruction-level reference model.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        alu_done = 1'b0;
   logic [31:0] incr_pc = 32'd0;
   logic        imem_req;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [1:0]  counter_selector;
   logic [2:0]  brtype;
   logic        halted;
   logic [15:0] retired;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_pc = 32'd0;
   logic [15:0] m_ret = 16'd0;

   pc_sequencer dut (
      .clk(clk),
      .rst(rst),
      .imem_ack(imem_ack),
      .instr(instr),
      .alu_done(alu_done),
      .incr_pc(incr_pc),
      .imem_req(imem_req),
      .pc(pc),
      .ir(ir),
      .counter_selector(counter_selector),
      .brtype(brtype),
      .halted(halted),
      .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_sel(input logic [31:0] w);
      if (w[31:29] == 3'd2) return 2'd1;
      if (w[31:29] == 3'd3) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [2:0] ref_bt(input logic [31:0] w);
      return (w[31:29] == 3'd1) ? w[28:26] : 3'd0;
   endfunction

   function automatic logic ref_alu(input logic [31:0] w);
      return !(w[31:29] inside {3'd1, 3'd2, 3'd3, 3'd7});
   endfunction

   // Starts and ends at a negedge while the DUT is fetching.
   task automatic run_instr(input logic [31:0] w, input int ack_wait,
                            input int alu_wait, input logic [31:0] nxt);
      logic [1:0] es;
      logic [2:0] eb;
      logic       alu;
      es  = ref_sel(w);
      eb  = ref_bt(w);
      alu = ref_alu(w);
      incr_pc = nxt;
      for (int i = 0; i < ack_wait; i++) begin
         imem_ack = 1'b0;
         instr = $urandom;
         alu_done = 1'($urandom);
         n_cmp++;
         if (imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_wait: imem_req=%b expected 1", imem_req);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (imem_req !== 1'b1 || counter_selector !== 2'd0 || brtype !== 3'd0) begin
         n_bad++;
         $display("FAIL fetch: req=%b sel=%0d bt=%0d expected 1/0/0",
                  imem_req, counter_selector, brtype);
      end
      imem_ack = 1'b1;
      instr = w;
      alu_done = 1'($urandom);
      @(negedge clk);
      imem_ack = 1'($urandom);
      instr = $urandom;
      n_cmp++;
      if (ir !== w || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL decode: ir=%h req=%b expected %h/0", ir, imem_req, w);
      end
      @(negedge clk);
      if (w[31:29] == 3'd7) begin
         n_cmp++;
         if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc ||
             retired !== m_ret || ir !== w) begin
            n_bad++;
            $display("FAIL halt_entry: halted=%b req=%b pc=%h ret=%h expected 1/0/%h/%h",
                     halted, imem_req, pc, retired, m_pc, m_ret);
         end
         return;
      end
      n_cmp++;
      if (halted !== 1'b0 || counter_selector !== es || brtype !== eb || pc !== m_pc) begin
         n_bad++;
         $display("FAIL exec: halted=%b sel=%0d bt=%0d pc=%h expected 0/%0d/%0d/%h",
                  halted, counter_selector, brtype, pc, es, eb, m_pc);
      end
      if (alu) begin
         for (int i = 0; i < alu_wait; i++) begin
            alu_done = 1'b0;
            imem_ack = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (pc !== m_pc || retired !== m_ret || counter_selector !== es) begin
               n_bad++;
               $display("FAIL alu_stall: pc=%h ret=%h sel=%0d expected %h/%h/%0d",
                        pc, retired, counter_selector, m_pc, m_ret, es);
            end
         end
      end
      alu_done = alu ? 1'b1 : 1'($urandom);
      @(negedge clk);
      alu_done = 1'($urandom);
      imem_ack = 1'($urandom);
      n_cmp++;
      if (counter_selector !== es || brtype !== eb || pc !== m_pc ||
          retired !== m_ret || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL update: sel=%0d bt=%0d pc=%h ret=%h expected %0d/%0d/%h/%h",
                  counter_selector, brtype, pc, retired, es, eb, m_pc, m_ret);
      end
      @(negedge clk);
      imem_ack = 1'b0;
      m_pc = nxt;
      m_ret = m_ret + 16'd1;
      n_cmp++;
      if (pc !== m_pc || retired !== m_ret || imem_req !== 1'b1 ||
          counter_selector !== 2'd0 || brtype !== 3'd0) begin
         n_bad++;
         $display("FAIL retire: pc=%h ret=%h req=%b sel=%0d bt=%0d expected %h/%h/1/0/0",
                  pc, retired, imem_req, counter_selector, brtype, m_pc, m_ret);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      imem_ack = 1'b1;
      instr = 32'hFFFF_FFFF;
      alu_done = 1'b1;
      incr_pc = 32'h1234;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (pc !== 32'd0) begin
         n_bad++; $display("FAIL reset_pc: got %h expected 0", pc);
      end
      n_cmp++;
      if (ir !== 32'd0) begin
         n_bad++; $display("FAIL reset_ir: got %h expected 0", ir);
      end
      n_cmp++;
      if (imem_req !== 1'b0 || halted !== 1'b0) begin
         n_bad++; $display("FAIL reset_flags: req=%b halted=%b expected 0/0", imem_req, halted);
      end
      n_cmp++;
      if (counter_selector !== 2'd0 || brtype !== 3'd0) begin
         n_bad++; $display("FAIL reset_sel: sel=%0d bt=%0d expected 0/0", counter_selector, brtype);
      end
      n_cmp++;
      if (retired !== 16'd0) begin
         n_bad++; $display("FAIL reset_retired: got %h expected 0", retired);
      end
      m_pc = 32'd0;
      m_ret = 16'd0;
   endtask

   task automatic test_release();
      instr = 32'd0;
      imem_ack = 1'b1;
      alu_done = 1'b1;
      incr_pc = 32'd4;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || pc !== 32'd0) begin
         n_bad++; $display("FAIL release: req=%b pc=%h expected 1/0", imem_req, pc);
      end
      run_instr(32'd0, 0, 0, 32'd4);
      run_instr(32'd0, 0, 0, 32'd8);
   endtask

   task automatic test_branch();
      run_instr(32'h2400_0047, 2, 0, 32'h11C);
   endtask

   task automatic test_jumps();
      run_instr(32'h4000_001A, 0, 0, $urandom);
      run_instr(32'h6000_0000, 1, 0, 32'd1045);
   endtask

   task automatic test_alu_stall();
      run_instr(32'h0000_1234, 0, 5, m_pc + 32'd4);
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic [31:0] nxt;
      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         w[31:29] = 3'($urandom_range(0, 6));
         nxt = (i == 5) ? 32'hFFFF_FFFC : (i == 6) ? 32'hFFFF_FFFF :
               (i == 7) ? 32'd0 : $urandom;
         run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), nxt);
      end
   endtask

   task automatic test_wrap();
      int n;
      n = 32'h0000_FFFF - int'(m_ret);
      imem_ack = 1'b1;
      alu_done = 1'b1;
      instr = 32'd0;
      incr_pc = 32'h100;
      repeat (4 * n) @(negedge clk);
      imem_ack = 1'b0;
      if (n > 0) m_pc = 32'h100;
      m_ret = 16'hFFFF;
      n_cmp++;
      if (retired !== m_ret || pc !== m_pc || imem_req !== 1'b1) begin
         n_bad++;
         $display("FAIL preload: ret=%h pc=%h req=%b expected %h/%h/1",
                  retired, pc, imem_req, m_ret, m_pc);
      end
      run_instr(32'h8000_0001, 0, 2, 32'h104);
      n_cmp++;
      if (retired !== 16'h0000) begin
         n_bad++; $display("FAIL wrap: retired=%h expected 0000", retired);
      end
   endtask

   task automatic test_reset_mid_fetch();
      rst = 1'b1;
      imem_ack = 1'b1;
      instr = 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++;
      if (ir !== 32'd0 || pc !== 32'd0 || retired !== 16'd0 || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_fetch: ir=%h pc=%h ret=%h req=%b expected 0/0/0/0",
                  ir, pc, retired, imem_req);
      end
      rst = 1'b0;
      imem_ack = 1'b0;
      @(negedge clk);
      m_pc = 32'd0;
      m_ret = 16'd0;
      n_cmp++;
      if (imem_req !== 1'b1 || ir !== 32'd0) begin
         n_bad++; $display("FAIL refetch: req=%b ir=%h expected 1/0", imem_req, ir);
      end
   endtask

   task automatic test_halt();
      run_instr(32'h1000_0000, 0, 1, 32'h40);
      run_instr(32'hE000_0000, 1, 0, 32'h5555);
      for (int i = 0; i < 20; i++) begin
         imem_ack = 1'b1;
         alu_done = 1'b1;
         instr = $urandom;
         incr_pc = $urandom;
         @(negedge clk);
         n_cmp++;
         if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== m_pc ||
             retired !== m_ret || ir !== 32'hE000_0000) begin
            n_bad++;
            $display("FAIL halt_hold: req=%b halted=%b pc=%h ret=%h ir=%h expected 0/1/%h/%h/e0000000",
                     imem_req, halted, pc, retired, ir, m_pc, m_ret);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (halted !== 1'b0 || pc !== 32'd0) begin
         n_bad++; $display("FAIL halt_reset: halted=%b pc=%h expected 0/0", halted, pc);
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_branch();
      test_jumps();
      test_alu_stall();
      test_random();
      test_wrap();
      test_reset_mid_fetch();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port imem_ack, input, 1: instruction memory has valid data on instr this cycle.
REQ-004 SHALL have port instr, input, 32: instruction word from instruction memory.
REQ-005 SHALL have port alu_done, input, 1: ALU-class instruction has completed.
REQ-006 SHALL have port incr_pc, input, 32: next PC computed by branch_control.
REQ-007 SHALL have port imem_req, output, 1: fetch request at address pc.
REQ-008 SHALL have port pc, output, 32: current program counter, fed to branch_control.pc.
REQ-009 SHALL have port ir, output, 32: latched instruction register.
REQ-010 SHALL have port counter_selector, output, 2: to branch_control; 0 = increment/branch, 1 = jump to label, 2 = jump to register; 3 never driven.
REQ-011 SHALL have port brtype, output, 3: to branch_control branch-condition select.
REQ-012 SHALL have port halted, output, 1: sticky halt indication.
REQ-013 SHALL have port retired, output, 16: count of instructions completed.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
REQ-015 SHALL go from IDLE to FETCH on the first clock with rst low.
REQ-016 SHALL drive imem_req high in FETCH only; FETCH holds until imem_ack is sampled high; on that edge ir <= instr and the FSM goes to DECODE.
REQ-017 SHALL ignore imem_ack in every state except FETCH; ack in the first FETCH cycle is accepted (fetch takes 1 cycle minimum).
REQ-018 SHALL decode class ir[31:29]: 000 ALU, 001 conditional branch, 010 jump-label, 011 jump-register, 111 halt; 100/101/110 treated as ALU.
REQ-019 SHALL, in DECODE, register counter_selector/brtype: branch -> 0 / ir[28:26]; jump-label -> 1 / 0; jump-register -> 2 / 0; ALU -> 0 / 0.
REQ-020 SHALL hold counter_selector and brtype stable from the cycle after DECODE through UPDATE, and return both to 0 in FETCH.
REQ-021 SHALL, from DECODE, go to HALT for class 111, otherwise to EXEC.
REQ-022 SHALL, in EXEC, wait for alu_done for ALU class (sampled only in EXEC, minimum 1 cycle); branch/jump classes leave EXEC after exactly 1 cycle.
REQ-023 SHALL, in UPDATE (1 cycle), load pc <= incr_pc, increment retired by 1 modulo 2^16 (0xFFFF wraps to 0x0000), then go to FETCH.
REQ-024 SHALL, in HALT, assert halted, freeze pc, ir and retired, keep imem_req low, and remain there until rst; the halt instruction is not counted.
REQ-025 SHALL keep pc 32 bits wide with no alignment checks; incr_pc is loaded verbatim, including wrap from 0xFFFFFFFF.
REQ-026 SHALL give a minimum of 4 cycles per non-halt instruction (FETCH, DECODE, EXEC, UPDATE).

Reset
REQ-027 SHALL, when rst is high at a clock edge in any state (including mid-FETCH with imem_ack high), set state = IDLE, pc = 0, ir = 0, imem_req = 0, counter_selector = 0, brtype = 0, halted = 0, retired = 0.
REQ-028 SHALL give rst priority over all other inputs; no instruction is latched or retired on a reset edge.

Verification
REQ-029 SHALL check reset release with imem_ack held high and instr = 0x00000000, alu_done = 1, incr_pc = pc+4: imem_req rises 1 cycle after IDLE, pc steps 0 -> 4 -> 8, and retired = 1 after the first UPDATE.
REQ-030 SHALL check branch fetch with instr = 0x24000047 (class 001, brtype 1): counter_selector = 0 and brtype = 1 from DECODE+1 through UPDATE; incr_pc = 0x11C is loaded into pc.
REQ-031 SHALL check jump-label 0x4000001A -> counter_selector = 1, and jump-register 0x60000000 with incr_pc = 1045 -> counter_selector = 2 and pc = 1045 after UPDATE.
REQ-032 SHALL check ALU stall: alu_done held low for 5 cycles in EXEC -> pc and retired unchanged until alu_done rises, then UPDATE follows on the next cycle.
REQ-033 SHALL check halt: instr = 0xE0000000 -> halted = 1, imem_req stays 0 for 20 cycles, pc frozen; then rst -> halted = 0, pc = 0.
REQ-034 SHALL check wrap and reset: preload retired to 0xFFFF via 65535 ALU instructions, retire one more -> retired = 0x0000; assert rst during FETCH with imem_ack = 1 -> ir stays 0.
